// File: rtl/booth_seq_pkg.sv
// booth_seq_pkg: shared FSM states, Booth window decode and sizing helpers for the radix-8 sequential multiplier
package booth_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [3:0] WIN_ZERO = 4'b0000;
  localparam logic [3:0] WIN_ONES = 4'b1111;
  localparam logic [2:0] SEL_0 = 3'd0;
  localparam logic [2:0] SEL_1 = 3'd1;
  localparam logic [2:0] SEL_2 = 3'd2;
  localparam logic [2:0] SEL_3 = 3'd3;
  localparam logic [2:0] SEL_4 = 3'd4;
  typedef struct packed {
    logic       neg;
    logic [2:0] sel;
  } mult_sel_t;
  function automatic int digits(int w);
    return (w + 2) / 3;
  endfunction
  function automatic int acc_w(int w);
    return 2 * w + 3;
  endfunction
  // digit = -4*w3 + 2*w2 + w1 + w0, split into sign and magnitude 0..4
  function automatic mult_sel_t booth_sel(logic [3:0] w);
    logic [2:0] s;
    s = {1'b0, w[2], 1'b0} + {2'b0, w[1]} + {2'b0, w[0]};
    return '{neg: w[3] && s != SEL_4, sel: w[3] ? SEL_4 - s : s};
  endfunction
endpackage

// File: rtl/booth_r8_digit_sel.sv
// booth_r8_digit_sel: maps a 4-bit Booth window to the signed multiple {0,+-1,+-2,+-3,+-4}*A
module booth_r8_digit_sel
  import booth_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       win,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH+2:0] a3,
  output logic [WIDTH+2:0] m
);
  mult_sel_t s;
  logic [WIDTH+2:0] ax, mag;
  always_comb begin
    s = booth_sel(win);
    ax = {{3{a[WIDTH-1]}}, a};
    mag = s.sel == SEL_1 ? ax :
          s.sel == SEL_2 ? ax << 1 :
          s.sel == SEL_3 ? a3 :
          s.sel == SEL_4 ? ax << 2 : '0;
    m = s.neg ? -mag : mag;
  end
endmodule

// File: rtl/booth_r8_seq_mult.sv
// booth_r8_seq_mult: iterative radix-8 Booth multiplier, one digit per clock; define BOOTH_SEQ_ZERO_SKIP_EN to finish early once remaining digits are zero
module booth_r8_seq_mult
  import booth_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               busy
);
  localparam int DG = digits(WIDTH);
  localparam int AW = acc_w(WIDTH);
  localparam int QW = WIDTH + 3;
  localparam int KW = $clog2(DG + 1);
  state_t state, state_n;
  logic [WIDTH-1:0] a_q;
  logic [QW-1:0] a3_q, m, q, q_sh, ax_in;
  logic [KW-1:0] k;
  logic [AW-1:0] acc, acc_n, m_ext;
  logic last;
  booth_r8_digit_sel #(.WIDTH(WIDTH)) u_sel (
    .win(q[3:0]),
    .a  (a_q),
    .a3 (a3_q),
    .m  (m)
  );
  assign ax_in = {{3{in_a[WIDTH-1]}}, in_a};
  assign q_sh  = $signed(q) >>> 3;
  assign m_ext = {{(AW-QW){m[QW-1]}}, m};
  assign acc_n = acc + (m_ext << (3 * k));
`ifdef BOOTH_SEQ_ZERO_SKIP_EN
  // all-equal shifted Q means every later window is 0000 or 1111
  assign last = k == KW'(DG - 1) || &q_sh || ~|q_sh;
`else
  assign last = k == KW'(DG - 1);
`endif
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE ? (in_valid ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) :
              (out_ready ? IDLE : DONE);
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    busy      = state != IDLE;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      a_q         <= '0;
      a3_q        <= '0;
      q           <= '0;
      k           <= '0;
      acc         <= '0;
      out_product <= '0;
    end else if (state == IDLE && in_valid) begin
      a_q  <= in_a;
      a3_q <= ax_in + (ax_in << 1);
      q    <= {{2{in_b[WIDTH-1]}}, in_b, 1'b0};
      k    <= '0;
      acc  <= '0;
    end else if (state == RUN) begin
      acc <= acc_n;
      q   <= q_sh;
      k   <= k + 1'b1;
      if (last) out_product <= acc_n[2*WIDTH-1:0];
    end
endmodule

// File: tb/tb_booth_r8_seq_mult.sv
// tb_booth_r8_seq_mult: directed vector table, handshake corner sequences and randomized stalls against a signed reference product
module tb_booth_r8_seq_mult;
  localparam int W = 16;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, busy;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic [2*W-1:0] out_product;
  int nvec = 0, nerr = 0;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;
  vec_t tbl[12];

  always #5 clk = ~clk;

  booth_r8_seq_mult #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .busy(busy)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(logic [15:0] b);
`ifdef BOOTH_SEQ_ZERO_SKIP_EN
    logic [18:0] q;
    q = {{2{b[15]}}, b, 1'b0};
    for (int n = 1; n < 6; n++) begin
      q = $signed(q) >>> 3;
      if (&q || ~|q) return n;
    end
`endif
    return 6 + 0 * int'(b[0]);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      tick();
      cnt++;
    end
  endtask

  task automatic run_pair(logic [15:0] a, logic [15:0] b, logic [31:0] p, bit stall, string name);
    int cnt;
    bit hs;
    cnt = 0;
    if (stall) repeat ($urandom_range(0, 2)) tick();
    while (!in_ready && cnt < 40) begin
      tick();
      cnt++;
    end
    in_valid = 1;
    in_a = a;
    in_b = b;
    tick();
    in_valid = 0;
    in_a = 16'($urandom);
    in_b = 16'($urandom);
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      if (stall) out_ready = 1'($urandom_range(0, 1));
      tick();
      cnt++;
    end
    check({name, " product"}, out_product, p);
    check({name, " latency"}, cnt, exp_lat(b));
    do begin
      if (stall) out_ready = 1'($urandom_range(0, 1));
      hs = out_ready;
      tick();
    end while (!hs);
    check({name, " release"}, {31'b0, out_valid}, 32'd0);
    out_ready = 1;
  endtask

  initial begin
    int cnt;
    logic [15:0] ra, rb;
    logic signed [31:0] sa, sb;
    tbl[0]  = '{16'd123,  16'hFFD3, 32'hFFFFEA61};
    tbl[1]  = '{16'h8000, 16'h8000, 32'h40000000};
    tbl[2]  = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
    tbl[3]  = '{16'h8000, 16'h7FFF, 32'hC0008000};
    tbl[4]  = '{16'd7,    16'd9,    32'h0000003F};
    tbl[5]  = '{16'd5,    16'hFFFF, 32'hFFFFFFFB};
    tbl[6]  = '{16'd1234, 16'd1,    32'h000004D2};
    tbl[7]  = '{16'd77,   16'd0,    32'h00000000};
    tbl[8]  = '{16'hFFFF, 16'hFFFF, 32'h00000001};
    tbl[9]  = '{16'd100,  16'd100,  32'h00002710};
    tbl[10] = '{16'hFED4, 16'd200,  32'hFFFF15A0};
    tbl[11] = '{16'd4,    16'hFFF8, 32'hFFFFFFE0};

    tick();
    tick();
    check("reset ctl", {29'b0, in_ready, out_valid, busy}, 32'b100);
    check("reset product", out_product, 32'd0);
    rst_n = 1;

    foreach (tbl[i]) run_pair(tbl[i].a, tbl[i].b, tbl[i].p, 0, $sformatf("vec%0d", i));

    // backpressure: product and flags held, new operands ignored
    out_ready = 0;
    in_valid = 1;
    in_a = 16'd123;
    in_b = 16'hFFD3;
    tick();
    in_valid = 0;
    wait_valid(cnt);
    check("bp latency", cnt, exp_lat(16'hFFD3));
    for (int i = 0; i < 10; i++) begin
      in_valid = 1;
      in_a = 16'd1;
      in_b = 16'd1;
      tick();
      check("bp hold ctl", {29'b0, in_ready, out_valid, busy}, 32'b011);
      check("bp hold product", out_product, 32'hFFFFEA61);
    end
    in_valid = 0;
    out_ready = 1;
    tick();
    check("bp release ctl", {29'b0, in_ready, out_valid, busy}, 32'b100);
    run_pair(16'd7, 16'd9, 32'd63, 0, "bp next");

    // output handshake and new input in the same DONE cycle
    out_ready = 0;
    in_valid = 1;
    in_a = 16'd2;
    in_b = 16'd3;
    tick();
    in_valid = 0;
    wait_valid(cnt);
    check("sim first product", out_product, 32'd6);
    out_ready = 1;
    in_valid = 1;
    in_a = 16'hFFFB;
    in_b = 16'd6;
    tick();
    check("sim idle ctl", {29'b0, in_ready, out_valid, busy}, 32'b100);
    tick();
    check("sim accept ctl", {29'b0, in_ready, out_valid, busy}, 32'b001);
    in_valid = 0;
    wait_valid(cnt);
    check("sim second product", out_product, 32'hFFFFFFE2);
    check("sim second latency", cnt, exp_lat(16'd6));
    tick();

    // reset in the middle of RUN
    in_valid = 1;
    in_a = 16'd1000;
    in_b = 16'd1000;
    tick();
    in_valid = 0;
    repeat (3) tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    check("midrst ctl", {29'b0, in_ready, out_valid, busy}, 32'b100);
    check("midrst product", out_product, 32'd0);
    run_pair(16'd7, 16'd9, 32'd63, 0, "midrst next");

    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 10 == 0) rb = 16'($urandom_range(0, 3)) - 16'd1;
      sa = $signed(ra);
      sb = $signed(rb);
      run_pair(ra, rb, sa * sb, 1, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
